// File: rtl/rfdc_adc_capture.sv
// rfdc_adc_capture: triggered, optionally decimated capture of 256-bit ADC stream beats into on-chip RAM,
// with 1-cycle host readback. Define RFDC_CAP_TIMESTAMP_EN to build the 48-bit trigger beat-time stamp.
module rfdc_adc_capture #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES      = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                              CLK100MHz,
  input  logic                              RST,
  input  logic [SAMPLE_WIDTH*SAMPLES-1:0]   s_axis_data_tdata,
  input  logic                              s_axis_data_tvalid,
  output logic                              s_axis_data_tready,
  input  logic                              arm,
  input  logic                              trig,
  input  logic [ADDR_WIDTH:0]               capture_len,
  input  logic [7:0]                        decim,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [SAMPLE_WIDTH*SAMPLES-1:0]   rd_data,
  output logic                              rd_valid,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_WIDTH:0]               captured_beats,
  output logic [47:0]                       trig_timestamp
);

  localparam int W     = SAMPLE_WIDTH * SAMPLES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len_q;
  logic [7:0]      decim_q;
  logic [7:0]      dcnt;
  logic [W-1:0]    mem [0:DEPTH-1];

  logic arm_ok, trig_ok, rd_ok, wr_en, last_wr;

  // Zero or oversize lengths mean "fill the whole buffer".
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
    if (l == '0 || l > LW'(DEPTH)) return LW'(DEPTH);
    else                           return l;
  endfunction

  assign s_axis_data_tready = 1'b1;
  assign busy    = (state == S_ARMED) || (state == S_CAPTURE);
  assign done    = (state == S_DONE);
  assign rd_ok   = (state == S_IDLE) || (state == S_DONE);
  assign arm_ok  = arm && rd_ok;
  assign trig_ok = trig && (state == S_ARMED);
  assign wr_en   = (state == S_CAPTURE) && s_axis_data_tvalid && (dcnt == 8'd0);
  assign last_wr = wr_en && ((captured_beats + 1'b1) == len_q);

  always_ff @(posedge CLK100MHz) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (arm)     state_nxt = S_ARMED;
      S_ARMED:        if (trig)    state_nxt = S_CAPTURE;
      S_CAPTURE:      if (last_wr) state_nxt = S_DONE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHz) begin
    if (arm_ok) begin
      len_q   <= sat_len(capture_len);
      decim_q <= decim;
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (RST) begin
      captured_beats <= '0;
      dcnt           <= '0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
    end else begin
      rd_valid <= rd_en && rd_ok;
      if (rd_en && rd_ok) rd_data <= mem[rd_addr];
      if (arm_ok)  captured_beats <= '0;
      if (trig_ok) dcnt <= '0;
      if (state == S_CAPTURE && s_axis_data_tvalid) begin
        dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
        if (dcnt == 8'd0) captured_beats <= captured_beats + 1'b1;
      end
    end
  end

  // Capture never exceeds len_q <= DEPTH, so the low address bits never wrap.
  always_ff @(posedge CLK100MHz) begin
    if (wr_en) mem[captured_beats[ADDR_WIDTH-1:0]] <= s_axis_data_tdata;
  end

`ifdef RFDC_CAP_TIMESTAMP_EN
  logic [47:0] beat_cnt;

  always_ff @(posedge CLK100MHz) begin
    if (RST) begin
      beat_cnt       <= '0;
      trig_timestamp <= '0;
    end else begin
      beat_cnt <= beat_cnt + 48'd1;
      if (trig_ok) trig_timestamp <= beat_cnt;
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_rfdc_adc_capture.sv
// Self-checking bench for rfdc_adc_capture: random beats against a queue-free index model of
// decimated capture, readback checks, arm/trig corner cases, mid-capture reset and trigger stamping.
module tb_rfdc_adc_capture;
  localparam int AW    = 10;
  localparam int W     = 256;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic [AW:0]   capture_len = '0;
  logic [7:0]    decim = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   captured_beats;
  logic [47:0]   trig_timestamp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [47:0] exp_ts = '0;
  logic [W-1:0] exp_mem [DEPTH];
  bit           known   [DEPTH];

  always #5 clk = ~clk;

  rfdc_adc_capture dut (
    .CLK100MHz(clk), .RST(rst),
    .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid), .s_axis_data_tready(tready),
    .arm(arm), .trig(trig), .capture_len(capture_len), .decim(decim),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .captured_beats(captured_beats), .trig_timestamp(trig_timestamp)
  );

  // cyc mirrors the beat counter: 0 in the first cycle after a reset edge.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [47:0] ts_model(input logic [47:0] v);
`ifdef RFDC_CAP_TIMESTAMP_EN
    return v;
`else
    return 48'd0 & v;
`endif
  endfunction

  function automatic int eff_len(input int len);
    return (len == 0 || len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic arm_trig(input int len, input int dec);
    arm = 1'b1; capture_len = (AW+1)'(len); decim = 8'(dec);
    tick();
    arm = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || captured_beats !== '0) begin
      bad++; $display("FAIL arm_state: busy=%0b done=%0b beats=%0d want busy=1 done=0 beats=0", busy, done, captured_beats);
    end
    trig = 1'b1; tvalid = 1'b1; tdata = rand_beat(); exp_ts = 48'(cyc);
    tick();
    trig = 1'b0; tvalid = 1'b0;
    total++;
    if (trig_timestamp !== ts_model(exp_ts)) begin
      bad++; $display("FAIL trig_ts: got=%0d want=%0d", trig_timestamp, ts_model(exp_ts));
    end
  endtask

  // Model: the i-th valid beat after CAPTURE entry is stored iff i % (dec+1) == 0, until len are stored.
  task automatic run_capture(input int len, input int dec, input int gap_pct, input int extra, input bit seq);
    int vcnt = 0;
    int stored = 0;
    int guard = 0;
    logic [W-1:0] d;
    while (stored < len && guard < 20000) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || captured_beats !== (AW+1)'(stored) || rd_valid !== 1'b0) begin
        bad++; $display("FAIL cap_progress: busy=%0b done=%0b beats=%0d rd_valid=%0b want busy=1 done=0 beats=%0d rd_valid=0",
                        busy, done, captured_beats, rd_valid, stored);
      end
      d = seq ? {16{16'(vcnt + 1)}} : rand_beat();
      tvalid = ($urandom_range(99) >= gap_pct); tdata = d;
      rd_en = 1'($urandom_range(1)); rd_addr = AW'($urandom_range(DEPTH - 1));
      if (tvalid) begin
        if (vcnt % (dec + 1) == 0) begin
          exp_mem[stored] = d; known[stored] = 1'b1; stored++;
        end
        vcnt++;
      end
      tick(); guard++;
    end
    tvalid = 1'b0; rd_en = 1'b0;
    total++;
    if (stored < len) begin
      bad++; $display("FAIL cap_timeout: stored=%0d want=%0d", stored, len);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || captured_beats !== (AW+1)'(len) || rd_valid !== 1'b0) begin
      bad++; $display("FAIL cap_done: done=%0b busy=%0b beats=%0d rd_valid=%0b want done=1 busy=0 beats=%0d rd_valid=0",
                      done, busy, captured_beats, rd_valid, len);
    end
    for (int i = 0; i < extra; i++) begin
      tvalid = 1'b1; tdata = seq ? {16{16'(vcnt + 1)}} : rand_beat(); vcnt++;
      tick();
    end
    tvalid = 1'b0;
    total++;
    if (done !== 1'b1 || captured_beats !== (AW+1)'(len)) begin
      bad++; $display("FAIL cap_hold: done=%0b beats=%0d want done=1 beats=%0d", done, captured_beats, len);
    end
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      total++;
      if (rd_valid !== 1'b1 || (known[a] && rd_data !== exp_mem[a])) begin
        bad++; $display("FAIL readback[%0d]: valid=%0b data=%h want valid=1 data=%h", a, rd_valid, rd_data, exp_mem[a]);
      end
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_idle: rd_valid=%0b want 0", rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || tready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl: busy=%0b done=%0b rd_valid=%0b tready=%0b want 0 0 0 1", busy, done, rd_valid, tready);
    end
    total++;
    if (rd_data !== '0 || captured_beats !== '0 || trig_timestamp !== '0) begin
      bad++; $display("FAIL reset_data: rd_data=%h beats=%0d ts=%0d want all 0", rd_data, captured_beats, trig_timestamp);
    end
  endtask

  task automatic test_full_depth();
    arm_trig(0, 0);
    run_capture(eff_len(0), 0, 0, 3, 1'b0);
    read_range(0, DEPTH - 1);
  endtask

  task automatic test_basic();
    arm_trig(4, 0);
    run_capture(4, 0, 0, 2, 1'b1);
    total++;
    if (exp_mem[3] !== {16{16'h0004}}) begin
      bad++; $display("FAIL basic_model: model[3]=%h want %h", exp_mem[3], {16{16'h0004}});
    end
    read_range(0, 5);
  endtask

  task automatic test_decim();
    arm_trig(3, 2);
    run_capture(3, 2, 30, 3, 1'b0);
    read_range(0, 3);
  endtask

  task automatic test_arm_trig_same();
    arm = 1'b1; trig = 1'b1; capture_len = 11'd4; decim = 8'd0; tvalid = 1'b1; tdata = rand_beat();
    tick();
    arm = 1'b0; trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = rand_beat(); rd_en = 1'b1; rd_addr = AW'(i);
      tick();
      total++;
      if (busy !== 1'b1 || captured_beats !== '0 || rd_valid !== 1'b0) begin
        bad++; $display("FAIL armed_hold: busy=%0b beats=%0d rd_valid=%0b want 1 0 0", busy, captured_beats, rd_valid);
      end
    end
    rd_en = 1'b0;
    trig = 1'b1; tdata = rand_beat(); exp_ts = 48'(cyc);
    tick();
    trig = 1'b0; tvalid = 1'b0;
    total++;
    if (trig_timestamp !== ts_model(exp_ts)) begin
      bad++; $display("FAIL trig_ts2: got=%0d want=%0d", trig_timestamp, ts_model(exp_ts));
    end
    run_capture(4, 0, 20, 0, 1'b0);
    read_range(0, 4);
  endtask

  task automatic test_reset_mid();
    arm_trig(8, 0);
    for (int i = 0; i < 2; i++) begin
      tvalid = 1'b1; tdata = rand_beat(); exp_mem[i] = tdata;
      tick();
    end
    tvalid = 1'b0;
    total++;
    if (captured_beats !== 11'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_partial: beats=%0d busy=%0b want 2 1", captured_beats, busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || captured_beats !== '0 || rd_valid !== 1'b0 || rd_data !== '0 || trig_timestamp !== '0) begin
      bad++; $display("FAIL mid_reset: busy=%0b done=%0b beats=%0d rd_valid=%0b ts=%0d want all 0",
                      busy, done, captured_beats, rd_valid, trig_timestamp);
    end
    read_range(0, 2);
  endtask

  task automatic test_timestamp();
    int guard = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    arm = 1'b1; capture_len = 11'd2; decim = 8'd0;
    tick();
    arm = 1'b0;
    while (cyc < 100 && guard < 200) begin tick(); guard++; end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    total++;
`ifdef RFDC_CAP_TIMESTAMP_EN
    if (trig_timestamp !== 48'd100) begin
      bad++; $display("FAIL ts_100: got=%0d want=100", trig_timestamp);
    end
`else
    if (trig_timestamp !== 48'd0) begin
      bad++; $display("FAIL ts_off: got=%0d want=0", trig_timestamp);
    end
`endif
    run_capture(2, 0, 0, 0, 1'b0);
    repeat (7) tick();
    total++;
    if (trig_timestamp !== ts_model(48'd100)) begin
      bad++; $display("FAIL ts_hold: got=%0d want=%0d", trig_timestamp, ts_model(48'd100));
    end
    arm_trig(3, 1);
    run_capture(3, 1, 10, 1, 1'b0);
  endtask

  task automatic test_random();
    int len, dec;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(40, 1);
      dec = $urandom_range(6, 0);
      arm_trig(len, dec);
      run_capture(len, dec, $urandom_range(50, 0), $urandom_range(3, 0), 1'b0);
      read_range(0, len + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_full_depth();
    test_basic();
    test_decim();
    test_arm_trig_same();
    test_reset_mid();
    test_timestamp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
